// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a master and the register-file completer.
interface apb_slave_regfile_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a DEPTH x 8-bit register file, a fixed number of wait
// states before pready, and an error response for out-of-range addresses.
// All bus outputs are registered and clear together when pready is low.
module apb_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input logic                pclk,
  input logic                prst,
  apb_slave_regfile_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  addr_q;
  logic        write_q;
  logic [7:0]  wdata_q;
  logic [7:0]  regs [DEPTH];

  logic [7:0]  sel_addr;
  logic        sel_write;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [7:0]  rsp_data;

  // Response that would be loaded into the output registers this cycle:
  // from the live bus in IDLE (zero-wait case), else from the captured setup.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    sel_addr  = addr_q;
    sel_write = write_q;
    rsp_data  = 8'h00;
    if (state == IDLE) begin
      sel_addr  = bus.paddr;
      sel_write = bus.pwrite;
    end
    in_range = ({1'b0, sel_addr} < 9'(DEPTH));
    idx      = sel_addr[AW-1:0];
    if (!sel_write && in_range) begin
      rsp_data = regs[idx];
    end
  end

  // Transfer FSM, wait counter, registered bus outputs and register file.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (prst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      bus.pready  <= 1'b0;
      bus.prdata  <= 8'h00;
      bus.pslverr <= 1'b0;
      // NOTE: the register file has a defined reset value, so it is cleared
      // here explicitly; this keeps it as flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
            cnt     <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state       <= READY;
              bus.pready  <= 1'b1;
              bus.prdata  <= rsp_data;
              bus.pslverr <= !in_range;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!bus.psel) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) begin
              state       <= READY;
              bus.pready  <= 1'b1;
              bus.prdata  <= rsp_data;
              bus.pslverr <= !in_range;
            end
          end
        end

        READY: begin
          if (!bus.psel) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.pready  <= 1'b0;
            bus.prdata  <= 8'h00;
            bus.pslverr <= 1'b0;
          end else if (bus.penable) begin
            if (write_q && in_range) begin
              regs[idx] <= wdata_q;
            end
            state       <= IDLE;
            bus.pready  <= 1'b0;
            bus.prdata  <= 8'h00;
            bus.pslverr <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          bus.pready  <= 1'b0;
          bus.prdata  <= 8'h00;
          bus.pslverr <= 1'b0;
        end
      endcase
    end
  end

endmodule
